sha256_stream_engine: RTL

- Parametrised SHA-256/SHA-224 hashing engine sitting between the testbench/host and the shared single-port word memory.
- Reads a raw, unpadded message of runtime length (in 32-bit words), applies padding in hardware, and processes any number of 512-bit blocks.
- Uses one compression round per cycle with an on-the-fly 16-word message schedule, so no 64-entry W array is needed.
- Writes the 8-word (SHA-256) or 7-word (SHA-224) digest back to memory.

---
 rtl/sha256_pkg.sv | 64 ++++++
 rtl/sha256_round.sv | 45 ++++
 rtl/sha256_stream_engine.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_pkg.sv
// SHA-256/SHA-224 shared constants, FSM encoding and bit-mixing helpers.
package sha256_pkg;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        COMPUTE,
        ADD,
        WRITE
    } state_e;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV_256 [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] IV_224 [0:7] = '{
        32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
        32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
    };

    function automatic logic [31:0] ror(
        input logic [31:0] x,
        input int unsigned n
    );
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-2 compression round: {a..h} -> next {a..h}.
module sha256_round
    import sha256_pkg::*;
(
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] c_i,
    input  logic [31:0] d_i,
    input  logic [31:0] e_i,
    input  logic [31:0] f_i,
    input  logic [31:0] g_i,
    input  logic [31:0] h_i,
    input  logic [31:0] w_i,
    input  logic [31:0] k_i,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic [31:0] c_o,
    output logic [31:0] d_o,
    output logic [31:0] e_o,
    output logic [31:0] f_o,
    output logic [31:0] g_o,
    output logic [31:0] h_o
);

    logic [31:0] ch;
    logic [31:0] maj;
    logic [31:0] t1;
    logic [31:0] t2;

    always_comb begin
        ch  = (e_i & f_i) ^ (~e_i & g_i);
        maj = (a_i & b_i) ^ (a_i & c_i) ^ (b_i & c_i);
        t1  = h_i + big_sigma1(e_i) + ch + k_i + w_i;
        t2  = big_sigma0(a_i) + maj;
        a_o = t1 + t2;
        b_o = a_i;
        c_o = b_i;
        d_o = c_i;
        e_o = d_i + t1;
        f_o = e_i;
        g_o = f_i;
        h_o = g_i;
    end

endmodule

// File: rtl/sha256_stream_engine.sv
// SHA-256/224 engine: reads a raw message from word memory, pads in
// hardware, compresses one round per cycle and writes the digest back.
module sha256_stream_engine
    import sha256_pkg::*;
#(
    parameter int MAX_WORDS = 64,
    parameter int ADDR_W    = 16,
    parameter int WCNT_W    = $clog2(MAX_WORDS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode_224,
    input  logic [WCNT_W-1:0] num_words,
    input  logic [ADDR_W-1:0] input_addr,
    input  logic [ADDR_W-1:0] hash_addr,
    input  logic [31:0]       memory_read_data,
    output logic              memory_clk,
    output logic [ADDR_W-1:0] memory_addr,
    output logic              enable_write,
    output logic [31:0]       memory_write_data,
    output logic              busy,
    output logic              done,
    output logic              error
);

    state_e            state_q, state_d;
    logic [6:0]        cnt_q, cnt_d;
    logic [WCNT_W-1:0] blk_q, blk_d;
    logic              err_q, err_d;
    logic              done_q, done_d;
    logic [WCNT_W-1:0] nw_q;
    logic              m224_q;
    logic [ADDR_W-1:0] iaddr_q;
    logic [ADDR_W-1:0] haddr_q;
    logic [31:0]       hv_q  [8];
    logic [31:0]       hv_d  [8];
    logic [31:0]       sv_q  [8];
    logic [31:0]       sv_d  [8];
    logic [31:0]       win_q [16];
    logic [31:0]       win_d [16];
    logic [31:0]       rnd   [8];

    logic [31:0] nw32;
    logic [31:0] blk32;
    logic [31:0] g_cap;
    logic [3:0]  j_cap;
    logic        is_last;
    logic        too_long;
    logic [31:0] fill_w;
    logic [31:0] sched_w;

    assign memory_clk = clk;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign error      = err_q;
    assign too_long   = 32'(num_words) > 32'(MAX_WORDS);

    sha256_round u_round (
        .a_i (sv_q[0]),
        .b_i (sv_q[1]),
        .c_i (sv_q[2]),
        .d_i (sv_q[3]),
        .e_i (sv_q[4]),
        .f_i (sv_q[5]),
        .g_i (sv_q[6]),
        .h_i (sv_q[7]),
        .w_i (win_q[0]),
        .k_i (K[cnt_q[5:0]]),
        .a_o (rnd[0]),
        .b_o (rnd[1]),
        .c_o (rnd[2]),
        .d_o (rnd[3]),
        .e_o (rnd[4]),
        .f_o (rnd[5]),
        .g_o (rnd[6]),
        .h_o (rnd[7])
    );

    // Data arriving in READ cycle cnt belongs to word cnt-1 of the block.
    always_comb begin
        nw32    = 32'(nw_q);
        blk32   = 32'(blk_q);
        is_last = (blk32 == ((nw32 + 32'd2) >> 4));
        j_cap   = cnt_q[3:0] - 4'd1;
        g_cap   = (blk32 << 4) + 32'(j_cap);
        if (g_cap < nw32) begin
            fill_w = memory_read_data;
        end else if (g_cap == nw32) begin
            fill_w = 32'h8000_0000;
        end else if (is_last && (j_cap == 4'hf)) begin
            fill_w = nw32 << 5;
        end else begin
            fill_w = '0;
        end
        sched_w = small_sigma1(win_q[14]) + win_q[9]
                + small_sigma0(win_q[1]) + win_q[0];
    end

    always_comb begin
        state_d           = state_q;
        cnt_d             = cnt_q;
        blk_d             = blk_q;
        err_d             = err_q;
        done_d            = 1'b0;
        hv_d              = hv_q;
        sv_d              = sv_q;
        win_d             = win_q;
        memory_addr       = '0;
        enable_write      = 1'b0;
        memory_write_data = '0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    err_d  = too_long;
                    done_d = too_long;
                    cnt_d  = '0;
                    blk_d  = '0;
                    for (int i = 0; i < 8; i++) begin
                        hv_d[i] = mode_224 ? IV_224[i] : IV_256[i];
                        sv_d[i] = mode_224 ? IV_224[i] : IV_256[i];
                    end
                    if (!too_long) begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                memory_addr = iaddr_q
                            + ADDR_W'((blk32 << 4) + 32'(cnt_q));
                if (cnt_q != 7'd0) begin
                    for (int i = 0; i < 15; i++) begin
                        win_d[i] = win_q[i+1];
                    end
                    win_d[15] = fill_w;
                end
                if (cnt_q == 7'd16) begin
                    state_d = COMPUTE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            COMPUTE: begin
                sv_d = rnd;
                for (int i = 0; i < 15; i++) begin
                    win_d[i] = win_q[i+1];
                end
                win_d[15] = sched_w;
                if (cnt_q == 7'd63) begin
                    state_d = ADD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            ADD: begin
                for (int i = 0; i < 8; i++) begin
                    hv_d[i] = hv_q[i] + sv_q[i];
                    sv_d[i] = hv_q[i] + sv_q[i];
                end
                cnt_d = '0;
                if (is_last) begin
                    state_d = WRITE;
                end else begin
                    blk_d   = blk_q + WCNT_W'(1);
                    state_d = READ;
                end
            end
            WRITE: begin
                enable_write      = 1'b1;
                memory_addr       = haddr_q + ADDR_W'(cnt_q);
                memory_write_data = hv_q[cnt_q[2:0]];
                if (cnt_q == (m224_q ? 7'd6 : 7'd7)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 7'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            blk_q   <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                hv_q[i] <= '0;
                sv_q[i] <= '0;
            end
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            blk_q   <= blk_d;
            err_q   <= err_d;
            done_q  <= done_d;
            hv_q    <= hv_d;
            sv_q    <= sv_d;
            win_q   <= win_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nw_q    <= '0;
            m224_q  <= 1'b0;
            iaddr_q <= '0;
            haddr_q <= '0;
        end else if ((state_q == IDLE) && start) begin
            nw_q    <= num_words;
            m224_q  <= mode_224;
            iaddr_q <= input_addr;
            haddr_q <= hash_addr;
        end
    end

endmodule
